truth_table_sequencer: RTL
==========================

Name: truth_table_sequencer

Overview:
- Self-test controller for a 4-input / 2-output combinational logic block.
- On start, it steps the 4-bit input space from 0 to 15 and waits a programmable settle time per vector.
- It samples the block's x/y outputs and compares them against expected truth tables held as parameters.
- It reports pass/fail, an error count and the first failing vector. It sits beside the logic block on the board-level test path.

Parameters:
- EXP_X, 16'hCF00, expected x; bit i is the expected x for input vector i = {a,b,c,d}.
- EXP_Y, 16'h0F54, expected y; same bit indexing.
- SETTLE_CYC, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  cancel the sweep; highest priority after reset.
- x_in  input  1  x output of the block under test.
- y_in  input  1  y output of the block under test.
- a  output  1  vector bit 3 (MSB) to the block under test.
- b  output  1  vector bit 2.
- c  output  1  vector bit 1.
- d  output  1  vector bit 0 (LSB).
- busy  output  1  high while in SETTLE or SAMPLE.
- done  output  1  one-cycle pulse at sweep completion.
- pass  output  1  last completed sweep had zero mismatches.
- err_cnt  output  5  mismatch count, 0..16.
- first_fail_idx  output  4  index of the first mismatching vector.
- first_fail_vld  output  1  first_fail_idx is meaningful.

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst_n low asynchronously forces state=IDLE and clears idx, settle counter and all outputs to 0 (a,b,c,d,busy,done,pass,err_cnt,first_fail_idx,first_fail_vld).
  - rst_n low mid-sweep has the same effect; no done pulse is produced.
- Vector mapping: {a,b,c,d} = idx, registered. Vector outputs are 0 in IDLE and DONE.
- IDLE:
  - start=1 → SETTLE. On the same edge: idx=0, settle cnt=0, err_cnt=0, pass=0, first_fail_vld=0, first_fail_idx=0.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYC-1 → SAMPLE.
- SAMPLE (exactly one cycle):
  - mis = (x_in != EXP_X[idx]) | (y_in != EXP_Y[idx]).
  - A mismatch on both x and y counts once.
  - On mis: err_cnt++ (saturates at 16); if first_fail_vld==0, first_fail_idx=idx and first_fail_vld=1.
  - If idx==15 → DONE; otherwise idx++, cnt=0 → SETTLE.
  - idx is 4-bit; the 15→0 wrap never occurs inside a sweep.
- DONE (one cycle):
  - done=1; pass=(err_cnt==0), using the final count including the last sample.
  - Next state is IDLE. pass, err_cnt and first_fail_* hold until the next accepted start.
- Latency: with start accepted at edge k, done is high in the cycle after edge k+16*(SETTLE_CYC+1)+1. With default SETTLE_CYC=2, that is edge k+49.
- busy: 1 in SETTLE and SAMPLE; 0 in IDLE and DONE.
- start while busy or in DONE: ignored.
- abort:
  - In SETTLE or SAMPLE: → IDLE next edge; no done; pass=0; err_cnt and first_fail_* keep their partial values.
  - abort and start together in IDLE: abort wins, so state stays IDLE.
- SETTLE_CYC outside 1..15: elaboration error.

Optional Feature:
- Macro: TTS_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes straight to DONE. err_cnt=1, first_fail_* are set, and done pulses the next cycle with pass=0.
- Undefined: the full 16-vector sweep always runs; err_cnt reports the total number of mismatches.

Test Plan:
- Model with x=EXP_X[idx], y=EXP_Y[idx], start at edge k → vectors 0..15 in order, each held 3 cycles; done at k+49; pass=1, err_cnt=0, first_fail_vld=0.
- y_in stuck at 0, x correct → err_cnt=7, first_fail_idx=2, pass=0.
- x_in inverted and y_in inverted → err_cnt=16 (no double count), first_fail_idx=0.
- abort during idx=5 → busy=0 next cycle, {a,b,c,d}=0, no done; a new start runs a full sweep and clears err_cnt.
- rst_n low mid-sweep at idx=9 → all outputs 0 immediately (asynchronous); start asserted during the sweep is ignored with no idx reset.
- TTS_STOP_ON_FAIL_EN defined, y_in stuck at 0 → done one cycle after the idx=2 sample; err_cnt=1, first_fail_idx=2, pass=0.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Handshake and test-path bundle for truth_table_sequencer.
// slave = sequencer side, master = stimulus / board side.
interface truth_table_sequencer_if;
    logic       start;
    logic       abort;
    logic       x_in;
    logic       y_in;
    logic       a;
    logic       b;
    logic       c;
    logic       d;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic [3:0] first_fail_idx;
    logic       first_fail_vld;

    modport slave (
        input  start, abort, x_in, y_in,
        output a, b, c, d, busy, done, pass,
        output err_cnt, first_fail_idx, first_fail_vld
    );

    modport master (
        output start, abort, x_in, y_in,
        input  a, b, c, d, busy, done, pass,
        input  err_cnt, first_fail_idx, first_fail_vld
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Truth-table self-test sweep for a 4-in/2-out logic block.
// Optional TTS_STOP_ON_FAIL_EN: end the sweep on the first mismatch.
module truth_table_sequencer #(
    parameter logic [15:0] EXP_X      = 16'hCF00,
    parameter logic [15:0] EXP_Y      = 16'h0F54,
    parameter int          SETTLE_CYC = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    truth_table_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [4:0] ERR_MAX  = 5'd16;

    generate
        if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
            $error("SETTLE_CYC must be within 1..15");
        end
    endgenerate

    logic [1:0] state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_q, err_d;
    logic [3:0] ffi_q, ffi_d;
    logic       ffv_q, ffv_d;
    logic       mis;
    logic       active_d;

    // One mismatch per vector even when both outputs disagree.
    assign mis = (bus.x_in != EXP_X[idx_q])
               | (bus.y_in != EXP_Y[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffi_d   = ffi_q;
        ffv_d   = ffv_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!bus.abort && bus.start) begin
                    state_d = S_SETTLE;
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    err_d   = 5'd0;
                    pass_d  = 1'b0;
                    ffi_d   = 4'd0;
                    ffv_d   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if (mis) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 5'd1;
                        end
                        if (!ffv_q) begin
                            ffi_d = idx_q;
                            ffv_d = 1'b1;
                        end
                    end
`ifdef TTS_STOP_ON_FAIL_EN
                    if (mis || idx_q == 4'd15) begin
`else
                    if (idx_q == 4'd15) begin
`endif
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SETTLE;
                        idx_d   = idx_q + 4'd1;
                        cnt_d   = 4'd0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                pass_d  = (err_q == 5'd0);
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign active_d = (state_d == S_SETTLE)
                    || (state_d == S_SAMPLE);
    assign busy_d   = active_d;
    assign vec_d    = active_d ? idx_d : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 5'd0;
            ffi_q   <= 4'd0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffi_q   <= ffi_d;
            ffv_q   <= ffv_d;
        end
    end

    assign bus.a              = vec_q[3];
    assign bus.b              = vec_q[2];
    assign bus.c              = vec_q[1];
    assign bus.d              = vec_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_cnt        = err_q;
    assign bus.first_fail_idx = ffi_q;
    assign bus.first_fail_vld = ffv_q;

endmodule
